// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD pixel back-end: RGB565 width, named colours,
// window-select encodings, the per-pixel tag that travels beside the RAM read,
// and the window priority function.
// -----------------------------------------------------------------------------
package lcd_pkg;

    localparam int RGB_W = 16;

    localparam logic [RGB_W-1:0] BLACK = 16'h0000;
    localparam logic [RGB_W-1:0] RED   = 16'hF800;
    localparam logic [RGB_W-1:0] WHITE = 16'hFFFF;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN0     = 2'b01,
        WIN1     = 2'b10
    } win_sel_e;

    // Everything about a pixel except its colour; delayed to meet the RAM data.
    // vld marks a sample taken after reset release, so flushed zeros are never
    // mistaken for a real low level of vsync.
    typedef struct packed {
        logic     vld;
        logic     hsync;
        logic     vsync;
        logic     de;
        win_sel_e sel;
    } pipe_tag_t;

    // Window 0 has priority when both acknowledges are high.
    function automatic win_sel_e win_select(input logic ack0, input logic ack1);
        if (ack0) return WIN0;
        if (ack1) return WIN1;
        return WIN_NONE;
    endfunction

endpackage

// File: rtl/lcd_delay_line.sv
// -----------------------------------------------------------------------------
// lcd_delay_line
// Fixed-depth shift register, cleared by reset.
// Ports:
//   clk, rest_n : clock, asynchronous active-low reset
//   i_d         : WIDTH-bit input sample
//   o_q         : i_d delayed by DEPTH clk cycles
// -----------------------------------------------------------------------------
module lcd_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rest_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    // NOTE: every stage is reset because it carries sync/control, and a stale
    // DE or window bit after reset would put garbage on the panel.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/lcd_pixel_pipe.sv
// -----------------------------------------------------------------------------
// lcd_pixel_pipe
// Back-end stage after the 640x480 timing generator: issues image RAM reads,
// retimes hsync/vsync/DE to the RAM latency and drives the RGB565 panel bus
// with background fill, window-1 tint and a frame counter.
// Latency input->output: RAM_LAT+2 (RAM_LAT+3 with PIXEL_PIPE_BORDER_EN).
// Build option: define PIXEL_PIPE_BORDER_EN for a red 1-pixel window-0 border.
// Ports:
//   clk, rest_n            : pixel clock, asynchronous active-low reset
//   in_hsync/vsync/de      : timing generator sync and data enable
//   in_ack0/in_ack1        : pixel inside window 0 / window 1
//   in_addr                : RAM address, one cycle after its ack
//   ram_rd_en/ram_rd_addr  : RAM read request (address 0 when idle)
//   ram_rd_data            : RAM data, RAM_LAT cycles after the request
//   lcd_hsync_o/vsync_o/de_o, lcd_rgb : panel bus
//   frame_cnt              : rising edges of lcd_vsync_o, wraps at 8 bits
// -----------------------------------------------------------------------------
module lcd_pixel_pipe
    import lcd_pkg::*;
#(
    parameter int               RAM_LAT     = 2,     // 1..4
    parameter logic [RGB_W-1:0] BG_COLOR    = BLACK,
    parameter logic [RGB_W-1:0] WIN1_XOR    = WHITE,
    parameter logic [RGB_W-1:0] BLANK_COLOR = BLACK
) (
    input  logic             clk,
    input  logic             rest_n,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic             in_de,
    input  logic             in_ack0,
    input  logic             in_ack1,
    input  logic [15:0]      in_addr,
    output logic             ram_rd_en,
    output logic [15:0]      ram_rd_addr,
    input  logic [RGB_W-1:0] ram_rd_data,
    output logic             lcd_hsync_o,
    output logic             lcd_vsync_o,
    output logic             lcd_de_o,
    output logic [RGB_W-1:0] lcd_rgb,
    output logic [7:0]       frame_cnt
);

    // ---------------- Stage A: align controls with in_addr ----------------
    pipe_tag_t r_tag_a;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the stage order cannot matter.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            r_tag_a <= '0;
        end else begin
            r_tag_a.vld   <= 1'b1;
            r_tag_a.hsync <= in_hsync;
            r_tag_a.vsync <= in_vsync;
            r_tag_a.de    <= in_de;
            r_tag_a.sel   <= win_select(in_ack0, in_ack1);
        end
    end

    // ---------------- Read issue ----------------
    assign ram_rd_en   = (r_tag_a.sel != WIN_NONE);
    assign ram_rd_addr = ram_rd_en ? in_addr : 16'h0000;

`ifdef PIXEL_PIPE_BORDER_EN
    // ---------------- Border detection (stage A) ----------------
    // Horizontal edges: previous pixel (r_prev_ack0) or next pixel (in_ack0,
    // one cycle ahead of stage A) outside window 0. Vertical edges: line index
    // within window 0; the last line is taken from the previous frame's count,
    // so the bottom edge appears from the second frame on.
    logic       r_prev_ack0;
    logic       r_line_has0;
    logic [9:0] r_line_idx;
    logic [9:0] r_win_lines;
    logic       w_is_ack0_a;
    logic       w_border_a;

    assign w_is_ack0_a = (r_tag_a.sel == WIN0);
    assign w_border_a  = w_is_ack0_a &&
                         (!r_prev_ack0 || !in_ack0 ||
                          r_line_idx == 10'd0 || r_line_idx == r_win_lines - 10'd1);

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            r_prev_ack0 <= 1'b0;
            r_line_has0 <= 1'b0;
            r_line_idx  <= '0;
            r_win_lines <= '0;
        end else begin
            r_prev_ack0 <= w_is_ack0_a;
            if (in_vsync && !r_tag_a.vsync) begin
                r_win_lines <= r_line_idx;
                r_line_idx  <= '0;
                r_line_has0 <= 1'b0;
            end else if (r_tag_a.de && !in_de) begin
                if (r_line_has0 || w_is_ack0_a) r_line_idx <= r_line_idx + 10'd1;
                r_line_has0 <= 1'b0;
            end else if (w_is_ack0_a) begin
                r_line_has0 <= 1'b1;
            end
        end
    end

    localparam int DL_W = $bits(pipe_tag_t) + 1;
    logic [DL_W-1:0] w_dl_in;
    logic [DL_W-1:0] w_dl_out;
    pipe_tag_t       w_tag_d;
    logic            w_border_d;
    assign w_dl_in               = {w_border_a, r_tag_a};
    assign {w_border_d, w_tag_d} = w_dl_out;
`else
    localparam int DL_W = $bits(pipe_tag_t);
    logic [DL_W-1:0] w_dl_in;
    logic [DL_W-1:0] w_dl_out;
    pipe_tag_t       w_tag_d;
    assign w_dl_in = r_tag_a;
    assign w_tag_d = w_dl_out;
`endif

    // ---------------- Delay line: tag meets RAM data ----------------
    lcd_delay_line #(
        .DEPTH (RAM_LAT),
        .WIDTH (DL_W)
    ) u_tag_dly (
        .clk    (clk),
        .rest_n (rest_n),
        .i_d    (w_dl_in),
        .o_q    (w_dl_out)
    );

    // ---------------- Pixel colour ----------------
    logic [RGB_W-1:0] w_rgb_next;

    // NOTE: default first so every path assigns w_rgb_next and no latch forms.
    always_comb begin
        w_rgb_next = BG_COLOR;
        if (!w_tag_d.de) begin
            w_rgb_next = BLANK_COLOR;
        end else begin
            case (w_tag_d.sel)
                WIN0:    w_rgb_next = ram_rd_data;
                WIN1:    w_rgb_next = ram_rd_data ^ WIN1_XOR;
                default: w_rgb_next = BG_COLOR;
            endcase
`ifdef PIXEL_PIPE_BORDER_EN
            if (w_border_d) w_rgb_next = RED;
`endif
        end
    end

    // ---------------- Inputs to the final output register ----------------
    logic             w_fin_hsync;
    logic             w_fin_vsync;
    logic             w_fin_de;
    logic             w_fin_vld;
    logic [RGB_W-1:0] w_fin_rgb;

`ifdef PIXEL_PIPE_BORDER_EN
    // Extra stage isolates the border override from the panel-facing flops.
    logic             r_hsync_o, r_vsync_o, r_de_o, r_vld_o;
    logic [RGB_W-1:0] r_rgb_o;

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            r_hsync_o <= 1'b0;
            r_vsync_o <= 1'b0;
            r_de_o    <= 1'b0;
            r_vld_o   <= 1'b0;
            r_rgb_o   <= BLANK_COLOR;
        end else begin
            r_hsync_o <= w_tag_d.hsync;
            r_vsync_o <= w_tag_d.vsync;
            r_de_o    <= w_tag_d.de;
            r_vld_o   <= w_tag_d.vld;
            r_rgb_o   <= w_rgb_next;
        end
    end

    assign w_fin_hsync = r_hsync_o;
    assign w_fin_vsync = r_vsync_o;
    assign w_fin_de    = r_de_o;
    assign w_fin_vld   = r_vld_o;
    assign w_fin_rgb   = r_rgb_o;
`else
    assign w_fin_hsync = w_tag_d.hsync;
    assign w_fin_vsync = w_tag_d.vsync;
    assign w_fin_de    = w_tag_d.de;
    assign w_fin_vld   = w_tag_d.vld;
    assign w_fin_rgb   = w_rgb_next;
`endif

    // ---------------- Output register and frame counter ----------------
    logic             r_hsync_f, r_vsync_f, r_de_f, r_vld_f;
    logic [RGB_W-1:0] r_rgb_f;
    logic [7:0]       r_frame_cnt;

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            r_hsync_f   <= 1'b0;
            r_vsync_f   <= 1'b0;
            r_de_f      <= 1'b0;
            r_vld_f     <= 1'b0;
            r_rgb_f     <= BLANK_COLOR;
            r_frame_cnt <= 8'd0;
        end else begin
            r_hsync_f <= w_fin_hsync;
            r_vsync_f <= w_fin_vsync;
            r_de_f    <= w_fin_de;
            r_vld_f   <= w_fin_vld;
            r_rgb_f   <= w_fin_rgb;
            // Count only a 0->1 between two real samples: a vsync already high
            // at reset release is not a new frame.
            if (w_fin_vld && r_vld_f && w_fin_vsync && !r_vsync_f)
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign lcd_hsync_o = r_hsync_f;
    assign lcd_vsync_o = r_vsync_f;
    assign lcd_de_o    = r_de_f;
    assign lcd_rgb     = r_rgb_f;
    assign frame_cnt   = r_frame_cnt;

endmodule
